// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and defaults for the frame SRAM port arbiter
package sram_arb_pkg;

   localparam int ADDR_W_DEF = 19;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2
   } port_t;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - owner selection: writer priority with starvation cap, round-robin between readers
module sram_arb_pick
   import sram_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       wclk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic       take,
   output logic [2:0] owner
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   port_t      rr_last;
   logic [3:0] starve_cnt;
   logic       rd_pend;

   assign rd_pend = req[1] | req[2];

   always_comb begin
      owner = 3'b000;
      if (req[0] && !(starve_cnt == LIMIT && rd_pend))
         owner = 3'b001;
      else if (req[1] && req[2])
         owner = (rr_last == P1) ? 3'b100 : 3'b010;
      else if (req[1])
         owner = 3'b010;
      else if (req[2])
         owner = 3'b100;
   end

   // starve_cnt only grows while a read is actually waiting behind the writer
   always_ff @(posedge wclk) begin
      if (rst) begin
         rr_last    <= P2;
         starve_cnt <= '0;
      end else if (take) begin
         if (owner[0]) begin
            if (!rd_pend)
               starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + 4'd1;
         end else begin
            starve_cnt <= '0;
            rr_last    <= owner[1] ? P1 : P2;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares the frame SRAM between the camera writer and two readers
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic              wclk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   input  logic              p1_req,
   input  logic [ADDR_W-1:0] p1_addr,
   output logic              p1_gnt,
   output logic [DATA_W-1:0] p1_rdata,
   input  logic              p2_req,
   input  logic [ADDR_W-1:0] p2_addr,
   output logic              p2_gnt,
   output logic [DATA_W-1:0] p2_rdata,
   output logic              sram_sel,
   output logic              sram_write,
   output logic              sram_read,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              busy
);

   state_t     state, state_n;
   logic [3:0] acc_cnt;
   logic [2:0] req, owner, owner_q;
   logic       take, last_beat;

   assign req       = {p2_req, p1_req, p0_req};
   assign last_beat = (state == S_ACCESS) && (acc_cnt == 4'd1);

   sram_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .wclk  (wclk),
      .rst   (rst),
      .req   (req),
      .take  (take),
      .owner (owner)
   );

   always_comb begin
      state_n = state;
      take    = 1'b0;
      case (state)
         S_IDLE: begin
            if (|req) begin
               take    = 1'b1;
               state_n = S_ACCESS;
            end
         end
         S_ACCESS: if (acc_cnt == 4'd1) state_n = S_DONE;
         S_DONE:   state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // Strobes, address and data are all flops so the SRAM pins never glitch
   always_ff @(posedge wclk) begin
      if (rst) begin
         state      <= S_IDLE;
         acc_cnt    <= '0;
         owner_q    <= '0;
         sram_sel   <= 1'b0;
         sram_write <= 1'b0;
         sram_read  <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         p0_gnt     <= 1'b0;
         p1_gnt     <= 1'b0;
         p2_gnt     <= 1'b0;
         p1_rdata   <= '0;
         p2_rdata   <= '0;
         busy       <= 1'b0;
      end else begin
         state  <= state_n;
         busy   <= (state_n != S_IDLE);
         p0_gnt <= last_beat && owner_q[0];
         p1_gnt <= last_beat && owner_q[1];
         p2_gnt <= last_beat && owner_q[2];
         if (take) begin
            owner_q    <= owner;
            acc_cnt    <= 4'(ACCESS_CYCLES);
            sram_sel   <= 1'b1;
            sram_write <= owner[0];
            sram_read  <= !owner[0];
            sram_addr  <= owner[0] ? p0_addr : (owner[1] ? p1_addr : p2_addr);
            if (owner[0])
               sram_wdata <= p0_wdata;
         end else if (state == S_ACCESS) begin
            acc_cnt <= acc_cnt - 4'd1;
            if (last_beat) begin
               sram_sel   <= 1'b0;
               sram_write <= 1'b0;
               sram_read  <= 1'b0;
               if (sram_read && owner_q[1]) p1_rdata <= sram_rdata;
               if (sram_read && owner_q[2]) p2_rdata <= sram_rdata;
            end
         end
      end
   end

endmodule
